// File: rtl/ahb_multi_arbiter_pkg.sv
// Shared types and default sizing for the multi-master AHB arbiter.
package ahb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_HOLD_LIMIT  = 16;

endpackage

// File: rtl/ahb_multi_arbiter_if.sv
// Bus bundle between the requesting masters and the arbiter.
interface ahb_multi_arbiter_if
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_W      = DEF_ADDR_W
);
    localparam int ID_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]             HRequestIn;
    logic [NUM_MASTERS-1:0][ADDR_W-1:0] HAddrIn;
    logic [NUM_MASTERS-1:0]             HWriteIn;
    logic                               HReady;
    logic [NUM_MASTERS-1:0]             HReadyOut;
    logic [ADDR_W-1:0]                  HAddr;
    logic                               HWrite;
    logic                               HRequest;
    logic [NUM_MASTERS-1:0]             Grant;
    logic [ID_W-1:0]                    GrantId;

    modport master (
        output HRequestIn, HAddrIn, HWriteIn, HReady,
        input  HReadyOut, HAddr, HWrite, HRequest, Grant, GrantId
    );

    modport slave (
        input  HRequestIn, HAddrIn, HWriteIn, HReady,
        output HReadyOut, HAddr, HWrite, HRequest, Grant, GrantId
    );

endinterface

// File: rtl/ahb_multi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick
    import ahb_arb_pkg::*;
#(
    parameter int N = DEF_NUM_MASTERS
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[(int'(start) + i) % N]) begin
                grant[(int'(start) + i) % N] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_multi_arbiter.sv
// Round-robin AHB bus arbiter with no-bubble handoff.
// Define ARB_HOLD_LIMIT_EN to force handoff after HOLD_LIMIT completed beats.
module ahb_multi_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int HOLD_LIMIT  = DEF_HOLD_LIMIT
) (
    input  logic                clk,
    input  logic                reset,
    ahb_multi_arbiter_if.slave  bus
);

    localparam int ID_W = $clog2(NUM_MASTERS);

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [ID_W-1:0]        last_q, last_d;
    logic [ID_W-1:0]        start_id, pick_id;
    logic [NUM_MASTERS-1:0] owner_oh, pick_oh;
    logic                   pick_valid;
    logic                   release_c;
    logic                   force_c;
    logic                   owned;

    // Search begins just past the last grant so the previous owner ranks lowest.
    always_comb begin
        if (int'(last_q) == NUM_MASTERS - 1) start_id = '0;
        else                                 start_id = last_q + ID_W'(1);
    end

    rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req   (bus.HRequestIn),
        .start (start_id),
        .grant (pick_oh),
        .valid (pick_valid)
    );

    always_comb begin
        owner_oh = '0;
        pick_id  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_q == ID_W'(i)) owner_oh[i] = 1'b1;
            if (pick_oh[i])          pick_id     = ID_W'(i);
        end
    end

    assign release_c = (state_q == OWNED) && bus.HReady &&
                       (!(|(bus.HRequestIn & owner_oh)) || force_c);

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(HOLD_LIMIT + 1);

    logic [CNT_W-1:0] beats_q;
    logic             new_grant;

    // beats_q holds beats already completed, so the limit fires on beat HOLD_LIMIT itself.
    assign force_c   = (beats_q >= CNT_W'(HOLD_LIMIT - 1)) &&
                       (|(bus.HRequestIn & ~owner_oh));
    assign new_grant = (state_d == OWNED) && ((state_q == IDLE) || release_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            beats_q <= '0;
        end else if (new_grant) begin
            beats_q <= '0;
        end else if ((state_q == OWNED) && bus.HReady &&
                     (beats_q != CNT_W'(HOLD_LIMIT))) begin
            beats_q <= beats_q + CNT_W'(1);
        end
    end
`else
    logic unused_hold_limit;

    assign force_c           = 1'b0;
    assign unused_hold_limit = (HOLD_LIMIT != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= ID_W'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWNED;
                    owner_d = pick_id;
                    last_d  = pick_id;
                end
            end
            OWNED: begin
                if (release_c) begin
                    if (pick_valid) begin
                        owner_d = pick_id;
                        last_d  = pick_id;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with reset keeps every output quiet during the reset cycle itself.
    assign owned = (state_q == OWNED) && !reset;

    always_comb begin
        bus.Grant     = '0;
        bus.GrantId   = '0;
        bus.HAddr     = '0;
        bus.HWrite    = 1'b0;
        bus.HRequest  = 1'b0;
        if (owned) begin
            bus.Grant    = owner_oh;
            bus.GrantId  = owner_q;
            bus.HAddr    = bus.HAddrIn[owner_q];
            bus.HWrite   = bus.HWriteIn[owner_q];
            bus.HRequest = bus.HRequestIn[owner_q];
        end
        bus.HReadyOut = bus.Grant & {NUM_MASTERS{bus.HReady}};
    end

endmodule

// File: tb/tb_ahb_multi_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_ahb_multi_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int HL = 16;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ahb_multi_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW)) bus ();

    ahb_multi_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .HOLD_LIMIT(HL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner index (-1 = nobody), last winner, beats completed by owner.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_beats = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(logic [N-1:0] req, int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    logic [N-1:0] mr;
    int           mw;
    bit           mrel, mothers;

    always @(posedge clk) begin
        mr = bus.HRequestIn;
        if (reset) begin
            m_owner = -1;
            m_last  = N - 1;
            m_beats = 0;
        end else if (m_owner < 0) begin
            mw = model_pick(mr, m_last);
            if (mw >= 0) begin
                m_owner = mw;
                m_last  = mw;
                m_beats = 0;
            end
        end else begin
            mothers = (mr & ~(N'(1) << m_owner)) != 0;
            mrel = bus.HReady &&
                   (!mr[m_owner] || (HOLD_EN && (m_beats + 1 >= HL) && mothers));
            if (bus.HReady) m_beats++;
            if (mrel) begin
                mw = model_pick(mr, m_last);
                if (mw >= 0) begin
                    m_owner = mw;
                    m_last  = mw;
                    m_beats = 0;
                end else begin
                    m_owner = -1;
                end
            end
        end
    end

    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    bit            ev;

    always @(negedge clk) begin
        ev = !reset && (m_owner >= 0);
        eg = ev ? (N'(1) << m_owner) : '0;
        ea = ev ? bus.HAddrIn[m_owner] : '0;
        check("grant",     64'(bus.Grant),     64'(eg));
        check("grant_id",  64'(bus.GrantId),   ev ? 64'(m_owner) : 64'd0);
        check("ready_out", 64'(bus.HReadyOut), 64'(eg & {N{bus.HReady}}));
        check("haddr",     64'(bus.HAddr),     64'(ea));
        check("hwrite",    64'(bus.HWrite),    ev ? 64'(bus.HWriteIn[m_owner]) : 64'd0);
        check("hrequest",  64'(bus.HRequest),  ev ? 64'(bus.HRequestIn[m_owner]) : 64'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.HRequestIn = '0;
        bus.HWriteIn   = '0;
        bus.HReady     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int rot_seq[5] = '{0, 1, 2, 3, 0};
    int run;
    bit done;
    int exp_run;

    initial begin
        reset          = 1'b1;
        bus.HRequestIn = '0;
        bus.HWriteIn   = '0;
        bus.HReady     = 1'b0;
        for (int i = 0; i < N; i++) bus.HAddrIn[i] = 32'hA000_0000 + 32'(i * 16);

        // First request after reset: master 0, one cycle latency
        do_reset();
        bus.HRequestIn = 4'b0001;
        @(negedge clk);
        check("idle_grant", 64'(bus.Grant), 64'h0);
        check("idle_haddr", 64'(bus.HAddr), 64'h0);
        step();
        @(negedge clk);
        check("first_grant", 64'(bus.Grant), 64'b0001);
        check("first_haddr", 64'(bus.HAddr), 64'hA000_0000);

        // Owner drops request while HReady low: grant must hold
        step();
        bus.HRequestIn = 4'b0010;
        bus.HReady     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("hold_wait_grant", 64'(bus.Grant), 64'b0001);
            check("hold_wait_rdy", 64'(bus.HReadyOut), 64'h0);
            step();
        end
        bus.HReady = 1'b1;
        @(negedge clk);
        check("hold_rel_grant", 64'(bus.Grant), 64'b0001);
        check("hold_rel_rdy", 64'(bus.HReadyOut), 64'b0001);
        step();
        bus.HRequestIn = 4'b0000;
        @(negedge clk);
        check("hold_next_grant", 64'(bus.Grant), 64'b0010);

        // All masters requesting, each releases after one beat
        do_reset();
        bus.HRequestIn = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            bus.HRequestIn = 4'b1111 & ~(N'(1) << m_owner);
            @(negedge clk);
            check("rotation_id", 64'(bus.GrantId), 64'(rot_seq[k]));
            check("rotation_grant", 64'(bus.Grant), 64'(N'(1) << rot_seq[k]));
            step();
        end

        // Master 1 streams 40 beats while master 0 waits
        do_reset();
        bus.HRequestIn = 4'b0010;
        step();
        run  = 0;
        done = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            bus.HRequestIn = 4'b0001 | ((c < 40) ? 4'b0010 : 4'b0000);
            @(negedge clk);
            if (!done) begin
                if (bus.Grant == 4'b0010) run++;
                else done = 1'b1;
            end
            step();
        end
        exp_run = HOLD_EN ? 16 : 40;
        check("hold_run", 64'(run), 64'(exp_run));

        // Reset while owned abandons the transfer
        do_reset();
        bus.HRequestIn = 4'b0010;
        step();
        reset          = 1'b1;
        bus.HRequestIn = 4'b0011;
        @(negedge clk);
        check("rst_cycle_rdy", 64'(bus.HReadyOut), 64'h0);
        check("rst_cycle_grant", 64'(bus.Grant), 64'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_grant", 64'(bus.Grant), 64'h0);
        step();
        @(negedge clk);
        check("post_rst_first", 64'(bus.Grant), 64'b0001);

        // Randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            step();
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                bus.HRequestIn[i] = ($urandom_range(0, 3) != 0);
                bus.HWriteIn[i]   = $urandom_range(0, 1) == 1;
                bus.HAddrIn[i]    = $urandom;
            end
            bus.HReady = ($urandom_range(0, 9) < 7);
        end
        step();
        reset = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
